// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control path:
// FSM state encodings, opcodes and datapath mux/ALU select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ORI_EXEC = 4'd10,
    S_ORI_WB   = 4'd11,
    S_ERR      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BRNV  = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory transaction open until mem_ack.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory state has waited without an acknowledge and
// flags a timeout once the count has reached MAX_WAIT with no ack.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  output logic timeout
);

  localparam int W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [W-1:0] wait_cnt_q;
  logic [W-1:0] wait_cnt_d;

  // Ack or timeout both leave the waiting state, so both clear the count.
  always_comb begin
    timeout    = waiting && !ack && (wait_cnt_q == W'(MAX_WAIT));
    wait_cnt_d = wait_cnt_q;
    if (!waiting || ack || timeout) wait_cnt_d = '0;
    else                            wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath. Outputs are decoded
// combinationally from the current state (and mem_ack in memory states).
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_write_cond_n,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             zero_ext,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic [3:0]       state_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_cnt_q;
  logic               timeout;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (is_mem_wait(state_q)),
    .ack     (mem_ack),
    .timeout (timeout)
  );

  // Next-state selection and per-state datapath control decode.
  always_comb begin
    state_d         = state_q;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_write_cond_n = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    reg_write       = 1'b0;
    zero_ext        = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = SRCB_B;
    alu_op          = ALU_ADD;
    pc_source       = PCSRC_ALU;
    retire          = 1'b0;
    halted          = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
        if (mem_ack)      state_d = S_DECODE;
        else if (timeout) state_d = S_ERR;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:        state_d = S_R_EXEC;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BRNV: state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ORI:          state_d = S_ORI_EXEC;
          default:         state_d = S_ERR;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ack)      state_d = S_MEM_WB;
        else if (timeout) state_d = S_ERR;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ack;
        if (mem_ack)      state_d = S_FETCH;
        else if (timeout) state_d = S_ERR;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = ALU_SUB;
        pc_source       = PCSRC_ALUOUT;
        pc_write_cond   = (opcode == OP_BEQ);
        pc_write_cond_n = (opcode == OP_BRNV);
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ORI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        zero_ext  = 1'b1;
        alu_op    = ALU_OR;
        state_d   = S_ORI_WB;
      end
      S_ORI_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ERR: begin
        halted  = 1'b1;
        state_d = S_ERR;
      end
      default: state_d = S_ERR;
    endcase
  end

  // State register and retired-instruction counter (wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      retired_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: timeout, each instruction class,
// ack-at-limit boundary, illegal opcode and reset mid-transaction.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BRNV  = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ack;
  logic        pc_write, pc_write_cond, pc_write_cond_n, iord;
  logic        mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic        reg_write, zero_ext, alu_src_a, retire, halted;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [15:0] retired_cnt;
  logic [3:0]  state_o;

  int n_checks;
  int n_pass;

  multicycle_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .opcode          (opcode),
    .mem_ack         (mem_ack),
    .pc_write        (pc_write),
    .pc_write_cond   (pc_write_cond),
    .pc_write_cond_n (pc_write_cond_n),
    .iord            (iord),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ir_write        (ir_write),
    .reg_dst         (reg_dst),
    .mem_to_reg      (mem_to_reg),
    .reg_write       (reg_write),
    .zero_ext        (zero_ext),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .alu_op          (alu_op),
    .pc_source       (pc_source),
    .retire          (retire),
    .retired_cnt     (retired_cnt),
    .halted          (halted),
    .state_o         (state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive inputs for the current cycle, let outputs settle, check state.
  task automatic at(input logic ack, input logic [5:0] op, input int exp_st, input string tag);
    mem_ack = ack;
    opcode  = op;
    #1;
    check({tag, ".state"}, 32'(state_o), exp_st);
  endtask

  // Zero-wait fetch + decode, leaving the FSM one edge past DECODE.
  task automatic fetch_decode(input logic [5:0] op, input string tag);
    at(1'b1, op, 0, {tag, ".f"});
    check({tag, ".ir_write"}, 32'(ir_write), 1);
    tick();
    at(1'b0, op, 1, {tag, ".d"});
    check({tag, ".d.srcb"}, 32'(alu_src_b), 3);
    tick();
  endtask

  task automatic run_branch(input logic [5:0] op, input int exp_c, input int exp_cn,
                            input int exp_cnt, input string tag);
    fetch_decode(op, tag);
    at(1'b0, op, 8, {tag, ".br"});
    check({tag, ".cond"},   32'(pc_write_cond),   exp_c);
    check({tag, ".cond_n"}, 32'(pc_write_cond_n), exp_cn);
    check({tag, ".pcsrc"},  32'(pc_source), 1);
    check({tag, ".aluop"},  32'(alu_op), 1);
    check({tag, ".retire"}, 32'(retire), 1);
    tick();
    at(1'b0, op, 0, {tag, ".end"});
    check({tag, ".cnt"}, 32'(retired_cnt), exp_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    mem_ack  = 1'b0;
    opcode   = 6'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and FETCH timeout.
    at(1'b0, 6'd0, 0, "rst");
    check("rst.mem_read", 32'(mem_read), 1);
    check("rst.ir_write", 32'(ir_write), 0);
    check("rst.srcb",     32'(alu_src_b), 1);
    check("rst.halted",   32'(halted), 0);
    check("rst.cnt",      32'(retired_cnt), 0);
    for (int i = 0; i < 15; i++) tick();
    at(1'b0, 6'd0, 0, "idle15");
    tick();
    at(1'b0, 6'd0, 12, "tmo");
    check("tmo.halted",   32'(halted), 1);
    check("tmo.mem_read", 32'(mem_read), 0);
    at(1'b1, 6'd0, 12, "tmo.ack");
    tick();
    at(1'b0, 6'd0, 12, "tmo.sticky");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at(1'b0, 6'd0, 0, "rst2");

    // lw with two wait cycles in MEM_RD.
    fetch_decode(OP_LW, "lw");
    at(1'b0, OP_LW, 2, "lw.a");
    check("lw.a.srca", 32'(alu_src_a), 1);
    check("lw.a.srcb", 32'(alu_src_b), 2);
    tick();
    at(1'b0, OP_LW, 3, "lw.r0");
    check("lw.r0.iord",  32'(iord), 1);
    check("lw.r0.rd",    32'(mem_read), 1);
    check("lw.r0.regwr", 32'(reg_write), 0);
    tick();
    at(1'b0, OP_LW, 3, "lw.r1");
    tick();
    at(1'b1, OP_LW, 3, "lw.r2");
    tick();
    at(1'b0, OP_LW, 4, "lw.wb");
    check("lw.wb.regwr", 32'(reg_write), 1);
    check("lw.wb.m2r",   32'(mem_to_reg), 1);
    check("lw.wb.ret",   32'(retire), 1);
    check("lw.wb.cnt",   32'(retired_cnt), 0);
    tick();
    at(1'b0, OP_LW, 0, "lw.end");
    check("lw.end.cnt",   32'(retired_cnt), 1);
    check("lw.end.regwr", 32'(reg_write), 0);

    // Branches.
    run_branch(OP_BEQ,  1, 0, 2, "beq");
    run_branch(OP_BRNV, 0, 1, 3, "brnv");

    // R-type.
    fetch_decode(OP_RTYPE, "r");
    at(1'b0, OP_RTYPE, 6, "r.ex");
    check("r.ex.aluop", 32'(alu_op), 2);
    check("r.ex.srcb",  32'(alu_src_b), 0);
    tick();
    at(1'b0, OP_RTYPE, 7, "r.wb");
    check("r.wb.regdst", 32'(reg_dst), 1);
    check("r.wb.regwr",  32'(reg_write), 1);
    tick();
    at(1'b0, OP_RTYPE, 0, "r.end");
    check("r.end.cnt", 32'(retired_cnt), 4);

    // ori.
    fetch_decode(OP_ORI, "ori");
    at(1'b0, OP_ORI, 10, "ori.ex");
    check("ori.ex.zext",  32'(zero_ext), 1);
    check("ori.ex.srcb",  32'(alu_src_b), 2);
    check("ori.ex.aluop", 32'(alu_op), 3);
    tick();
    at(1'b0, OP_ORI, 11, "ori.wb");
    check("ori.wb.regwr",  32'(reg_write), 1);
    check("ori.wb.regdst", 32'(reg_dst), 0);
    check("ori.wb.m2r",    32'(mem_to_reg), 0);
    tick();
    at(1'b0, OP_ORI, 0, "ori.end");
    check("ori.end.cnt", 32'(retired_cnt), 5);

    // lw with ack arriving exactly at the wait limit.
    fetch_decode(OP_LW, "lim");
    at(1'b0, OP_LW, 2, "lim.a");
    tick();
    for (int i = 0; i < 15; i++) begin
      at(1'b0, OP_LW, 3, "lim.wait");
      tick();
    end
    at(1'b1, OP_LW, 3, "lim.ack");
    tick();
    at(1'b0, OP_LW, 4, "lim.wb");
    tick();
    at(1'b0, OP_LW, 0, "lim.end");
    check("lim.end.cnt", 32'(retired_cnt), 6);

    // sw interrupted by reset while waiting in MEM_WR.
    fetch_decode(OP_SW, "sw");
    at(1'b0, OP_SW, 2, "sw.a");
    tick();
    at(1'b0, OP_SW, 5, "sw.w0");
    check("sw.w0.wr",  32'(mem_write), 1);
    check("sw.w0.ret", 32'(retire), 0);
    tick();
    at(1'b0, OP_SW, 5, "sw.w1");
    check("sw.w1.wcnt", 32'(dut.u_timer.wait_cnt_q), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at(1'b0, 6'd0, 0, "sw.rst");
    check("sw.rst.wr",   32'(mem_write), 0);
    check("sw.rst.cnt",  32'(retired_cnt), 0);
    check("sw.rst.wcnt", 32'(dut.u_timer.wait_cnt_q), 0);

    // Illegal opcode.
    at(1'b1, OP_BAD, 0, "bad.f");
    tick();
    at(1'b0, OP_BAD, 1, "bad.d");
    tick();
    at(1'b1, OP_BAD, 12, "bad.err");
    check("bad.halted", 32'(halted), 1);
    tick();
    at(1'b1, OP_BAD, 12, "bad.ack");
    check("bad.rd", 32'(mem_read), 0);
    tick();
    at(1'b0, OP_BAD, 12, "bad.sticky");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at(1'b0, 6'd0, 0, "bad.rst");
    check("bad.rst.halted", 32'(halted), 0);
    check("bad.rst.cnt",    32'(retired_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences a multi-cycle version of the team's MIPS-subset datapath: one shared byte memory for instructions and data, one ALU, and IR/MDR/A/B/ALUOut holding registers.
- Each cycle it decodes the opcode and drives every datapath select and enable.
- It waits on a memory acknowledge handshake.
- It flags illegal opcodes and memory timeouts.
- It counts retired instructions.

Parameters:
- MAX_WAIT, 15, cycles a memory state may wait for mem_ack before the error state is entered.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- mem_ack  in  1  memory completed the current read or write this cycle.
- pc_write, pc_write_cond, pc_write_cond_n  out  1 each  unconditional PC load / load if zero / load if not zero (brnv).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- zero_ext  out  1  ALU immediate extension: 0 = sign-extend, 1 = zero-extend.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B operand: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- retire  out  1  one-cycle pulse in an instruction's final cycle.
- retired_cnt  out  CNT_W  count of retired instructions; wraps.
- halted  out  1  FSM is in ERR.
- state_o  out  4  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ORI_EXEC=10, ORI_WB=11, ERR=12.
- Outputs are combinational from state and mem_ack. Any output not listed for a state is 0.
- Reset: state=FETCH, wait_cnt=0, retired_cnt=0. Outputs therefore take FETCH values: mem_read=1, alu_src_b=01, all others 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ack. Goes to DECODE on mem_ack, otherwise stays.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001101 -> ORI_EXEC
  - any other opcode -> ERR
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Goes to MEM_WB on mem_ack.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Next FETCH.
- MEM_WR: iord=1, mem_write=1. On mem_ack: retire=1, next FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_dst=1, reg_write=1, retire=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, retire=1. pc_write_cond=1 if opcode=000100; pc_write_cond_n=1 if opcode=000101. Next FETCH.
- JUMP: pc_source=10, pc_write=1, retire=1. Next FETCH.
- ORI_EXEC: alu_src_a=1, alu_src_b=10, zero_ext=1, alu_op=11. Next ORI_WB.
- ORI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. Next FETCH.
- ERR: halted=1; every other output 0, including mem_read. Sticky until rst.
- Memory handshake and wait_cnt:
  - wait_cnt increments each cycle spent in FETCH, MEM_RD or MEM_WR without mem_ack.
  - It clears on any state change.
  - If wait_cnt==MAX_WAIT and mem_ack=0, next state is ERR.
  - mem_ack in the same cycle as the limit wins: normal advance.
  - mem_ack outside FETCH, MEM_RD and MEM_WR is ignored.
- retired_cnt increments on every cycle where retire=1, wrapping at 2^CNT_W.
- Latency with zero-wait memory (mem_ack=1 in the first cycle):
  - R-type 4, lw 5, sw 4, beq/brnv 3, j 3, ori 4 cycles.
  - Each extra memory wait cycle adds 1.
- opcode is sampled only in DECODE, MEM_ADDR and BRANCH; the IR holds it stable there.
- rst has priority over everything and takes effect at the next edge from any state, including mid-wait and ERR. retired_cnt clears.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state encodings
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BRNV, OP_J, OP_ORI
  - alu_src_b, alu_op and pc_source encodings
- One sub-module, mem_wait_timer: wait_cnt plus timeout compare. Inputs clk, rst, waiting, ack; output timeout.
- Next-state logic and output decode stay in multicycle_ctrl.

Test Plan:
- Reset then idle, mem_ack=0: state_o=0, mem_read=1, ir_write=0. After 15 cycles still FETCH; on the 16th edge state_o=12, halted=1, mem_read=0.
- lw (opcode 100011), mem_ack=1 in FETCH, mem_ack delayed 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,4,0. reg_write=mem_to_reg=1 only in state 4. retired_cnt 0->1.
- beq then brnv, zero-wait memory: each takes 3 cycles. BRANCH asserts pc_write_cond=1 for beq and pc_write_cond_n=1 for brnv, never both. retire pulses twice.
- ori (001101): ORI_EXEC shows zero_ext=1, alu_src_b=10, alu_op=11. ORI_WB shows reg_write=1, reg_dst=0.
- Illegal opcode 111111 in DECODE: next state ERR, halted=1. Further mem_ack pulses have no effect. rst returns to FETCH with retired_cnt=0.
- Reset asserted while in MEM_WR with mem_ack=0: next edge state_o=0, mem_write=0, no retire pulse, wait_cnt cleared.
